// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 add/sub, A op B -> S with flags {invalid,overflow,inexact}, in/out valid-ready handshake
module fp_addsub_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   S,
  output logic [2:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 1;
  localparam int X = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] EINF = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic adv, v1, v2;
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap, far, nan_in, inf_inf;
  logic [EXP_W-1:0] ea, eb, ea_e, eb_e, el, es, d;
  logic [MAN_W-1:0] fa, fb;
  logic [M-1:0] ma, mb, ml, ms;
  logic [2*X-1:0] sh;
  logic [X-1:0] al;
  logic [W-1:0] spec_val;
  logic s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [X-1:0] s1_ml, s1_ms;
  logic [W-1:0] s1_sval;
  logic [2:0] s1_sflg;
  logic s2_sign, s2_zsign, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [X:0] s2_sum;
  logic [W-1:0] s2_sval;
  logic [2:0] s2_sflg;
  logic carry, g, r, st, rup, inx, ovf, zero, sgn;
  logic [EW-1:0] e0, lim, lz, shift, e1, e2, exp_f;
  logic [X-1:0] norm;
  logic [M-1:0] mant;
  logic [M:0] mr;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] res;
  logic [2:0] res_f;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  always_comb begin
    sa = A[W-1];
    sb = B[W-1] ^ op;
    ea = A[W-2:MAN_W];
    eb = B[W-2:MAN_W];
    fa = A[MAN_W-1:0];
    fb = B[MAN_W-1:0];
    a_nan = &ea && |fa;
    b_nan = &eb && |fb;
    a_inf = &ea && !(|fa);
    b_inf = &eb && !(|fb);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    ma = {|ea, fa};
    mb = {|eb, fb};
    ea_e = (|ea) ? ea : EXP_W'(1);
    eb_e = (|eb) ? eb : EXP_W'(1);
    swap = {eb, fb} > {ea, fa};
    el = swap ? eb_e : ea_e;
    es = swap ? ea_e : eb_e;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    d = el - es;
    far = 32'(d) >= 32'(MAN_W + 3);
    sh = {ms, 3'b000, {X{1'b0}}} >> d;
    al = far ? {{(X-1){1'b0}}, |ms} : sh[2*X-1:X] | {{(X-1){1'b0}}, |sh[X-1:0]};
    nan_in = a_nan || b_nan;
    inf_inf = a_inf && b_inf && (sa ^ sb);
    spec_val = (nan_in || inf_inf) ? QNAN : a_inf ? {sa, A[W-2:0]} : {sb, B[W-2:0]};
  end
  always_comb begin
    carry = s2_sum[X];
    e0 = {2'b00, s2_exp};
    lim = e0 - 1'b1;
    lz = EW'(X);
    for (int i = 0; i < X; i++) if (s2_sum[i]) lz = EW'(X - 1 - i);
    shift = (lz > lim) ? lim : lz;
    norm = carry ? {s2_sum[X:2], s2_sum[1] | s2_sum[0]} : s2_sum[X-1:0] << shift;
    e1 = carry ? e0 + 1'b1 : e0 - shift;
    mant = norm[X-1:3];
    g = norm[2];
    r = norm[1];
    st = norm[0];
    inx = g | r | st;
    rup = g & (r | st | mant[0]);
    mr = {1'b0, mant} + {{M{1'b0}}, rup};
    e2 = mr[M] ? e1 + 1'b1 : e1;
    exp_f = (mr[M] | mr[M-1]) ? e2 : '0;
    frac = mr[M] ? '0 : mr[MAN_W-1:0];
    ovf = exp_f >= EINF;
    zero = !(|s2_sum);
    sgn = zero ? s2_zsign : s2_sign;
    res = s2_spec ? s2_sval : ovf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, exp_f[EXP_W-1:0], frac};
    res_f = s2_spec ? s2_sflg : ovf ? 3'b011 : {2'b00, inx};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      S <= '0;
      flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      S <= res;
      flags <= res_f;
    end
  end
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= swap ? sb : sa;
      s1_sub <= sa ^ sb;
      s1_exp <= el;
      s1_ml <= {ml, 3'b000};
      s1_ms <= al;
      s1_spec <= nan_in || a_inf || b_inf;
      s1_sval <= spec_val;
      s1_sflg <= {a_snan || b_snan || inf_inf, 2'b00};
      s2_sum <= s1_sub ? {1'b0, s1_ml} - {1'b0, s1_ms} : {1'b0, s1_ml} + {1'b0, s1_ms};
      s2_exp <= s1_exp;
      s2_sign <= s1_sign;
      s2_zsign <= !s1_sub && s1_sign;
      s2_spec <= s1_spec;
      s2_sval <= s1_sval;
      s2_sflg <= s1_sflg;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of fp_addsub_pipe results, flags, latency, stall and reset behaviour
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic op = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [63:0] S;
  logic [2:0] flags;
  int total = 0;
  int bad = 0;
  logic [63:0] va [8];
  logic [63:0] vb [8];
  logic [63:0] vs [8];
  logic vo [8];
  logic [2:0] vf [8];
  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic o,
                        input logic [63:0] es, input logic [2:0] ef);
    int n;
    A = a;
    B = b;
    op = o;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_s"}, S, es);
    chk({tag, "_f"}, 64'(flags), 64'(ef));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int pushed, popped;
    va[0] = 64'h3FF0000000000000; vb[0] = 64'h4000000000000000; vo[0] = 0; vs[0] = 64'h4008000000000000; vf[0] = 3'b000;
    va[1] = 64'h4008000000000000; vb[1] = 64'h3FF0000000000000; vo[1] = 1; vs[1] = 64'h4000000000000000; vf[1] = 3'b000;
    va[2] = 64'h3FF8000000000000; vb[2] = 64'h3FF8000000000000; vo[2] = 0; vs[2] = 64'h4008000000000000; vf[2] = 3'b000;
    va[3] = 64'h3FF0000000000000; vb[3] = 64'h4000000000000000; vo[3] = 1; vs[3] = 64'hBFF0000000000000; vf[3] = 3'b000;
    va[4] = 64'h3FE0000000000000; vb[4] = 64'h3FD0000000000000; vo[4] = 0; vs[4] = 64'h3FE8000000000000; vf[4] = 3'b000;
    va[5] = 64'hBFF0000000000000; vb[5] = 64'hBFF0000000000000; vo[5] = 0; vs[5] = 64'hC000000000000000; vf[5] = 3'b000;
    va[6] = 64'h7FF0000000000000; vb[6] = 64'h3FF0000000000000; vo[6] = 0; vs[6] = 64'h7FF0000000000000; vf[6] = 3'b000;
    va[7] = 64'h7FF0000000000001; vb[7] = 64'h3FF0000000000000; vo[7] = 0; vs[7] = 64'h7FF8000000000000; vf[7] = 3'b100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_s", S, 64'd0);
    chk("rst_f", 64'(flags), 64'd0);
    rst = 1'b0;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    run_op("one_one", 64'h3FF0000000000000, 64'h3FF0000000000000, 0, 64'h4000000000000000, 3'b000);
    run_op("x_minus_x", 64'h3FF0000000000000, 64'h3FF0000000000000, 1, 64'h0000000000000000, 3'b000);
    run_op("neg_zero", 64'h8000000000000000, 64'h8000000000000000, 0, 64'h8000000000000000, 3'b000);
    run_op("ovf", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 64'h7FF0000000000000, 3'b011);
    run_op("inf_inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 0, 64'h7FF8000000000000, 3'b100);
    run_op("inf_sub", 64'h7FF0000000000000, 64'h7FF0000000000000, 1, 64'h7FF8000000000000, 3'b100);
    run_op("tie_even", 64'h3FF0000000000000, 64'h3CA0000000000000, 0, 64'h3FF0000000000000, 3'b001);
    run_op("tie_odd", 64'h3FF0000000000001, 64'h3CA0000000000000, 0, 64'h3FF0000000000002, 3'b001);
    run_op("rnd_up", 64'h3FF0000000000000, 64'h3CA0000000000001, 0, 64'h3FF0000000000001, 3'b001);
    run_op("subn_add", 64'h0000000000000001, 64'h0000000000000001, 0, 64'h0000000000000002, 3'b000);
    run_op("subn_res", 64'h0010000000000000, 64'h0000000000000001, 1, 64'h000FFFFFFFFFFFFF, 3'b000);
    run_op("far", 64'h3FF0000000000000, 64'h0000000000000001, 0, 64'h3FF0000000000000, 3'b001);
    run_op("fin_inf", 64'h3FF0000000000000, 64'h7FF0000000000000, 1, 64'hFFF0000000000000, 3'b000);
    run_op("qnan", 64'h7FF8000000000000, 64'h3FF0000000000000, 0, 64'h7FF8000000000000, 3'b000);
    @(posedge clk);
    #1;
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 40 && popped < 8; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid = pushed < 8;
      if (pushed < 8) begin
        A = va[pushed];
        B = vb[pushed];
        op = vo[pushed];
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stall_rdy", 64'(in_ready), 64'd0);
        chk("stall_s", S, vs[popped]);
      end
      if (out_valid && out_ready) begin
        chk("str_s", S, vs[popped]);
        chk("str_f", 64'(flags), 64'(vf[popped]));
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("str_cnt", 64'(popped), 64'd8);
    A = 64'h3FF0000000000000;
    B = 64'h3FF0000000000000;
    op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    A = 64'h4000000000000000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_ov", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    run_op("post_rst", 64'h3FF0000000000000, 64'h4000000000000000, 0, 64'h4008000000000000, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
